dt_mem_resp: RTL



---
 rtl/dt_mem_resp.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/dt_mem_resp.sv
// Memory responder for the distance-transform host: streams in the sti image, serves 1-cycle host
// reads/writes, then dumps the result RAM over valid/ready (outputs frozen while dump_ready is low).
module dt_mem_resp #(
  parameter int STI_DEPTH = 1024,
  parameter int STI_W     = 16,
  parameter int RES_DEPTH = 16384,
  parameter int RES_W     = 8,
  localparam int SA = $clog2(STI_DEPTH),
  localparam int RA = $clog2(RES_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [STI_W-1:0] load_data,
  output logic             load_ready,
  output logic             load_done,
  input  logic             sti_rd,
  input  logic [SA-1:0]    sti_addr,
  output logic [STI_W-1:0] sti_di,
  input  logic             res_rd,
  input  logic             res_wr,
  input  logic [RA-1:0]    res_addr,
  input  logic [RES_W-1:0] res_do,
  output logic [RES_W-1:0] res_di,
  input  logic             done,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [RA-1:0]    dump_addr,
  output logic [RES_W-1:0] dump_data,
  output logic             dump_last,
  output logic             err
);

  typedef enum logic [2:0] {S_LOAD, S_SERVE, S_DUMP_PF, S_DUMP, S_END} state_t;

  localparam logic [RA-1:0] LAST_ADDR = RA'(RES_DEPTH - 1);

  state_t r_state, w_state_nxt;

  logic [STI_W-1:0] r_sti [STI_DEPTH];
  logic [RES_W-1:0] r_res [RES_DEPTH];

  logic [SA-1:0]    r_load_ptr;
  logic             r_load_ready, r_load_done, r_err;
  logic [STI_W-1:0] r_sti_di;
  logic [RES_W-1:0] r_res_di, r_dump_data;
  logic [RA-1:0]    r_dump_addr;
  logic             r_dump_valid, r_dump_last;

  logic          w_load_fire, w_host_acc, w_serve, w_res_wr_en, w_res_rd_en;
  logic          w_dump_fire, w_err_set;
  logic [RA-1:0] w_dump_next, w_dump_raddr;

  assign w_load_fire  = load_valid & r_load_ready;
  assign w_host_acc   = sti_rd | res_rd | res_wr;
  assign w_serve      = (r_state == S_SERVE);
  assign w_res_wr_en  = w_serve & res_wr;
  // A simultaneous read/write keeps the write and drops the read.
  assign w_res_rd_en  = w_serve & res_rd & ~res_wr;
  assign w_dump_fire  = (r_state == S_DUMP) & r_dump_valid & dump_ready;
  assign w_dump_next  = r_dump_addr + RA'(1);
  assign w_dump_raddr = (r_state == S_DUMP_PF) ? '0 : w_dump_next;
  assign w_err_set    = ((r_state == S_LOAD) | (r_state == S_DUMP_PF) | (r_state == S_DUMP)) & w_host_acc
                      | w_serve & res_rd & res_wr;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:    if (w_load_fire && r_load_ptr == '1) w_state_nxt = S_SERVE;
      S_SERVE:   if (done) w_state_nxt = S_DUMP_PF;
      S_DUMP_PF: w_state_nxt = S_DUMP;
      S_DUMP:    if (w_dump_fire && r_dump_last) w_state_nxt = S_END;
      S_END:     w_state_nxt = S_END;
      default:   w_state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_load_fire) r_sti[r_load_ptr] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (w_res_wr_en) r_res[res_addr] <= res_do;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_LOAD;
      r_load_ptr   <= '0;
      r_load_ready <= 1'b0;
      r_load_done  <= 1'b0;
      r_sti_di     <= '0;
      r_res_di     <= '0;
      r_err        <= 1'b0;
      r_dump_valid <= 1'b0;
      r_dump_addr  <= '0;
      r_dump_data  <= '0;
      r_dump_last  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_load_ready <= (w_state_nxt == S_LOAD);
      if (w_load_fire) begin
        r_load_ptr <= r_load_ptr + SA'(1);
        if (r_load_ptr == '1) r_load_done <= 1'b1;
      end
      if (w_serve && sti_rd) r_sti_di <= r_sti[sti_addr];
      if (w_res_rd_en)       r_res_di <= r_res[res_addr];
      if (w_err_set)         r_err    <= 1'b1;
      // Prefetch of entry 0 happens in DUMP_PF; valid rises one cycle later.
      if (r_state == S_DUMP_PF) begin
        r_dump_addr <= '0;
        r_dump_data <= r_res[w_dump_raddr];
        r_dump_last <= 1'b0;
      end else if (r_state == S_DUMP) begin
        if (!r_dump_valid) begin
          r_dump_valid <= 1'b1;
        end else if (w_dump_fire) begin
          if (r_dump_last) begin
            r_dump_valid <= 1'b0;
            r_dump_last  <= 1'b0;
          end else begin
            r_dump_addr <= w_dump_next;
            r_dump_data <= r_res[w_dump_raddr];
            r_dump_last <= (w_dump_next == LAST_ADDR);
          end
        end
      end
    end
  end

  assign load_ready = r_load_ready;
  assign load_done  = r_load_done;
  assign sti_di     = r_sti_di;
  assign res_di     = r_res_di;
  assign err        = r_err;
  assign dump_valid = r_dump_valid;
  assign dump_addr  = r_dump_addr;
  assign dump_data  = r_dump_data;
  assign dump_last  = r_dump_last;

endmodule
